// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: walks the PC linearly, applies execute-stage redirects,
// freezes on stall, halts on request or illegal target, and keeps debug counters.
module pc_sequencer #(
  parameter int PC_W   = 9,
  parameter int RCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              PcSel,
  input  logic [31:0]       BrPC,
  input  logic              HaltReq,
  input  logic              Resume,
  output logic [PC_W-1:0]   Cur_PC,
  output logic              IfValid,
  output logic              Flush,
  output logic              Halted,
  output logic              MisalignErr,
  output logic [RCNT_W-1:0] RedirectCnt,
  output logic [31:0]       FetchCnt
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [PC_W-1:0]     pc, pc_next;
  logic                mis_set;
  logic                redirect_take;
  logic                fetch_take;
  logic                target_ok;
  logic [RCNT_W-1:0]   rcnt;
  logic [31:0]         fcnt;
  logic                mis;

  function automatic logic [RCNT_W-1:0] sat_inc(input logic [RCNT_W-1:0] v);
    sat_inc = (&v) ? v : v + RCNT_W'(1);
  endfunction

  function automatic logic [PC_W-1:0] pc_advance(input logic [PC_W-1:0] v);
    pc_advance = v + PC_W'(4);
  endfunction

  // A target is usable only if word aligned and inside the PC address space.
  function automatic logic legal_target(input logic [31:0] t);
    legal_target = (t[1:0] == 2'b00) && (t[31:PC_W] == '0);
  endfunction

  assign target_ok = legal_target(BrPC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_BOOT;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    IfValid       = 1'b0;
    Flush         = 1'b0;
    Halted        = 1'b0;
    mis_set       = 1'b0;
    redirect_take = 1'b0;
    fetch_take    = 1'b0;
    case (state)
      ST_BOOT: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        IfValid = 1'b1;
        if (HaltReq) begin
          // Writeback halt is older than any execute redirect, so it wins.
          Flush      = 1'b1;
          state_next = ST_HALTED;
        end else if (PcSel && !target_ok) begin
          Flush      = 1'b1;
          mis_set    = 1'b1;
          state_next = ST_HALTED;
        end else if (PcSel) begin
          Flush         = 1'b1;
          pc_next       = BrPC[PC_W-1:0];
          redirect_take = 1'b1;
        end else if (!Stall) begin
          pc_next    = pc_advance(pc);
          fetch_take = 1'b1;
        end
      end
      ST_HALTED: begin
        Halted = 1'b1;
        if (Resume) state_next = ST_RUN;
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mis  <= 1'b0;
      rcnt <= '0;
      fcnt <= '0;
    end else begin
      if (mis_set)       mis  <= 1'b1;
      if (redirect_take) rcnt <= sat_inc(rcnt);
      if (fetch_take)    fcnt <= fcnt + 32'd1;
    end
  end

  assign Cur_PC      = pc;
  assign MisalignErr = mis;
  assign RedirectCnt = rcnt;
  assign FetchCnt    = fcnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle comparison against a spec-level
// model, plus literal expectations at key points of each scenario.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Stall = 1'b0;
  logic        PcSel = 1'b0;
  logic [31:0] BrPC = 32'd0;
  logic        HaltReq = 1'b0;
  logic        Resume = 1'b0;
  logic [8:0]  Cur_PC;
  logic        IfValid;
  logic        Flush;
  logic        Halted;
  logic        MisalignErr;
  logic [15:0] RedirectCnt;
  logic [31:0] FetchCnt;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  pc_sequencer #(.PC_W(9), .RCNT_W(16)) dut (
    .clk(clk), .reset(rst_n), .Stall(Stall), .PcSel(PcSel), .BrPC(BrPC),
    .HaltReq(HaltReq), .Resume(Resume), .Cur_PC(Cur_PC), .IfValid(IfValid),
    .Flush(Flush), .Halted(Halted), .MisalignErr(MisalignErr),
    .RedirectCnt(RedirectCnt), .FetchCnt(FetchCnt)
  );

  always #5 clk = ~clk;

  // Model: mode 0 = boot cycle, 1 = running, 2 = halted.
  int          m_mode = 0;
  int unsigned m_pc = 0;
  bit          m_mis = 1'b0;
  int unsigned m_rcnt = 0;
  longint      m_fcnt = 0;

  function automatic bit model_legal(input logic [31:0] t);
    return (t % 4 == 0) && (t < 512);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_pc <= 0; m_mis <= 1'b0; m_rcnt <= 0; m_fcnt <= 0;
    end else if (m_mode == 0) begin
      m_mode <= 1;
    end else if (m_mode == 2) begin
      if (Resume) m_mode <= 1;
    end else if (HaltReq) begin
      m_mode <= 2;
    end else if (PcSel && !model_legal(BrPC)) begin
      m_mis <= 1'b1; m_mode <= 2;
    end else if (PcSel) begin
      m_pc <= BrPC % 512;
      m_rcnt <= (m_rcnt == 65535) ? m_rcnt : m_rcnt + 1;
    end else if (!Stall) begin
      m_pc <= (m_pc + 4) % 512;
      m_fcnt <= (m_fcnt + 1) % 64'h1_0000_0000;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_pc", 64'(Cur_PC), 64'(m_pc));
      chk("m_ifvalid", 64'(IfValid), 64'(rst_n && m_mode == 1));
      chk("m_flush", 64'(Flush), 64'(rst_n && m_mode == 1 && (HaltReq || PcSel)));
      chk("m_halted", 64'(Halted), 64'(rst_n && m_mode == 2));
      chk("m_mis", 64'(MisalignErr), 64'(m_mis));
      chk("m_rcnt", 64'(RedirectCnt), 64'(m_rcnt));
      chk("m_fcnt", 64'(FetchCnt), 64'(m_fcnt));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [31:0] fcnt_hold;

  initial begin
    #1 rst_n = 1'b0;
    #1 check_en = 1'b1;
    chk("rst_pc", 64'(Cur_PC), 64'h0);
    chk("rst_ifvalid", 64'(IfValid), 64'h0);
    chk("rst_halted", 64'(Halted), 64'h0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    #1;
    // Boot cycle, then linear fetch.
    chk("boot_pc", 64'(Cur_PC), 64'h0);
    chk("boot_ifvalid", 64'(IfValid), 64'h0);
    cyc(); chk("run0_pc", 64'(Cur_PC), 64'h0);
    chk("run0_ifvalid", 64'(IfValid), 64'h1);
    cyc(); chk("run1_pc", 64'(Cur_PC), 64'h4);
    cyc(); chk("run2_pc", 64'(Cur_PC), 64'h8);
    cyc(); chk("run3_pc", 64'(Cur_PC), 64'hC);
    cyc(5); chk("pre_redir_pc", 64'(Cur_PC), 64'h20);
    // Legal redirect.
    PcSel = 1'b1; BrPC = 32'h0000_0100; #1;
    chk("redir_flush", 64'(Flush), 64'h1);
    cyc(); PcSel = 1'b0;
    chk("redir_pc", 64'(Cur_PC), 64'h100);
    chk("redir_cnt", 64'(RedirectCnt), 64'h1);
    // Stall holds PC and fetch count; redirect overrides stall.
    PcSel = 1'b1; BrPC = 32'h40; cyc(); PcSel = 1'b0;
    Stall = 1'b1; fcnt_hold = FetchCnt;
    cyc(3);
    chk("stall_pc", 64'(Cur_PC), 64'h40);
    chk("stall_fcnt", 64'(FetchCnt), 64'(fcnt_hold));
    PcSel = 1'b1; BrPC = 32'h80; cyc(); PcSel = 1'b0; Stall = 1'b0;
    chk("stall_redir_pc", 64'(Cur_PC), 64'h80);
    chk("stall_redir_cnt", 64'(RedirectCnt), 64'h3);
    // Misaligned target halts.
    PcSel = 1'b1; BrPC = 32'h0000_0102; #1;
    chk("mis_flush", 64'(Flush), 64'h1);
    cyc(); PcSel = 1'b0;
    chk("mis_err", 64'(MisalignErr), 64'h1);
    chk("mis_halted", 64'(Halted), 64'h1);
    chk("mis_pc", 64'(Cur_PC), 64'h80);
    PcSel = 1'b1; BrPC = 32'h0; Stall = 1'b1; #1;
    chk("halt_noflush", 64'(Flush), 64'h0);
    cyc(2);
    chk("halt_ignore_pc", 64'(Cur_PC), 64'h80);
    PcSel = 1'b0; Stall = 1'b0; Resume = 1'b1; HaltReq = 1'b1;
    cyc(); Resume = 1'b0; HaltReq = 1'b0;
    chk("resume_halted", 64'(Halted), 64'h0);
    chk("resume_pc", 64'(Cur_PC), 64'h80);
    chk("resume_mis", 64'(MisalignErr), 64'h1);
    cyc(); chk("resume_next_pc", 64'(Cur_PC), 64'h84);
    // Out-of-range target halts.
    PcSel = 1'b1; BrPC = 32'h0000_0400; cyc(); PcSel = 1'b0;
    chk("range_halted", 64'(Halted), 64'h1);
    chk("range_pc", 64'(Cur_PC), 64'h84);
    Resume = 1'b1; cyc(); Resume = 1'b0;
    chk("range_resume_pc", 64'(Cur_PC), 64'h84);
    // HaltReq beats PcSel.
    PcSel = 1'b1; BrPC = 32'h10; cyc();
    HaltReq = 1'b1; BrPC = 32'h100; #1;
    chk("hr_flush", 64'(Flush), 64'h1);
    cyc(); HaltReq = 1'b0; PcSel = 1'b0;
    chk("hr_halted", 64'(Halted), 64'h1);
    chk("hr_pc", 64'(Cur_PC), 64'h10);
    chk("hr_cnt", 64'(RedirectCnt), 64'h4);
    Resume = 1'b1; cyc(); Resume = 1'b0;
    // PC wrap.
    PcSel = 1'b1; BrPC = 32'h1F8; cyc(); PcSel = 1'b0;
    chk("wrap_a", 64'(Cur_PC), 64'h1F8);
    cyc(); chk("wrap_b", 64'(Cur_PC), 64'h1FC);
    cyc(); chk("wrap_c", 64'(Cur_PC), 64'h000);
    // Redirect counter saturation.
    PcSel = 1'b1; BrPC = 32'h100;
    cyc(65540);
    chk("sat_cnt", 64'(RedirectCnt), 64'hFFFF);
    cyc();
    chk("sat_hold", 64'(RedirectCnt), 64'hFFFF);
    // Asynchronous reset in the middle of a redirect.
    rst_n = 1'b0; #1;
    chk("arst_pc", 64'(Cur_PC), 64'h0);
    chk("arst_rcnt", 64'(RedirectCnt), 64'h0);
    chk("arst_fcnt", 64'(FetchCnt), 64'h0);
    chk("arst_mis", 64'(MisalignErr), 64'h0);
    chk("arst_flush", 64'(Flush), 64'h0);
    cyc(); PcSel = 1'b0; rst_n = 1'b1; #1;
    chk("rboot_ifvalid", 64'(IfValid), 64'h0);
    cyc(); chk("rrun_pc", 64'(Cur_PC), 64'h0);
    cyc(); chk("rrun_next_pc", 64'(Cur_PC), 64'h4);
    cyc();
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
